// File: rtl/multicycle_control_unit.sv
// Purpose: Moore control FSM sequencing fetch/decode/execute/memory/writeback for a multi-cycle RV32I core.
// Latency: zero-wait memory gives R/I/LUI/AUIPC 4 cycles, load 5, store 4, branch/JAL/JALR 3, NOP 2.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold their request until memory_response; TRAP holds until reset.
module multicycle_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       memory_response,
  input  logic       branch_taken,
  output logic       memory_read,
  output logic       memory_write,
  output logic       lord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_source,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       illegal_instruction,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  // State and sticky trap flag registers; reset restarts at FETCH and clears the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and Moore outputs; reset forces every output low so no request or write escapes.
  always_comb begin
    state_d             = state_q;
    illegal_d           = illegal_q;
    memory_read         = 1'b0;
    memory_write        = 1'b0;
    lord                = 1'b0;
    ir_write            = 1'b0;
    pc_write            = 1'b0;
    pc_source           = 1'b0;
    alu_src_a           = 2'd0;
    alu_src_b           = 2'd0;
    alu_op              = 2'd0;
    reg_write           = 1'b0;
    mem_to_reg          = 2'd0;
    illegal_instruction = illegal_q;
    state               = state_q;

    case (state_q)
      S_FETCH: begin
        memory_read = 1'b1;
        alu_src_b   = 2'd1;
        if (memory_response) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU-out captures PC+imm speculatively for branch/JAL targets.
        alu_src_b = 2'd2;
        case (opcode)
          OP_LOAD, OP_STORE:   state_d = S_MEMADR;
          OP_RTYPE:            state_d = S_EXECUTER;
          OP_ITYPE:            state_d = S_EXECUTEI;
          OP_BRANCH:           state_d = S_BRANCH;
          OP_JAL:              state_d = S_JAL;
          OP_JALR:             state_d = S_JALR;
          OP_LUI:              state_d = S_LUI;
          OP_AUIPC:            state_d = S_AUIPC;
          OP_SYSTEM, OP_FENCE: state_d = S_FETCH;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        memory_read = 1'b1;
        lord        = 1'b1;
        if (memory_response) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        memory_write = 1'b1;
        lord         = 1'b1;
        if (memory_response) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'd1;
        alu_op    = 2'd2;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        alu_op    = 2'd2;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'd1;
        alu_op    = 2'd1;
        pc_source = 1'b1;
        pc_write  = branch_taken;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // PC already holds the link value (old PC + 4).
        reg_write  = 1'b1;
        mem_to_reg = 2'd2;
        pc_write   = 1'b1;
        pc_source  = 1'b1;
        state_d    = S_FETCH;
      end
      S_JALR: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        reg_write  = 1'b1;
        mem_to_reg = 2'd2;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd2;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'd3;
        alu_src_b = 2'd2;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        illegal_instruction = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (reset) begin
      memory_read         = 1'b0;
      memory_write        = 1'b0;
      lord                = 1'b0;
      ir_write            = 1'b0;
      pc_write            = 1'b0;
      pc_source           = 1'b0;
      alu_src_a           = 2'd0;
      alu_src_b           = 2'd0;
      alu_op              = 2'd0;
      reg_write           = 1'b0;
      mem_to_reg          = 2'd0;
      illegal_instruction = 1'b0;
      state               = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed stimulus for multicycle_control_unit: each step drives inputs, checks all outputs, then clocks.
// Expected output words are hand-built per state from the control table.
// Output word layout: {state, illegal, mem_rd, mem_wr, lord, ir_wr, pc_wr, pc_src, src_a, src_b, alu_op, reg_wr, mem_to_reg}.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       memory_response;
  logic       branch_taken;
  logic       memory_read, memory_write, lord, ir_write, pc_write, pc_source;
  logic [1:0] alu_src_a, alu_src_b, alu_op, mem_to_reg;
  logic       reg_write, illegal_instruction;
  logic [3:0] state;

  int vectors = 0;
  int errors  = 0;

  multicycle_control_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .opcode              (opcode),
    .memory_response     (memory_response),
    .branch_taken        (branch_taken),
    .memory_read         (memory_read),
    .memory_write        (memory_write),
    .lord                (lord),
    .ir_write            (ir_write),
    .pc_write            (pc_write),
    .pc_source           (pc_source),
    .alu_src_a           (alu_src_a),
    .alu_src_b           (alu_src_b),
    .alu_op              (alu_op),
    .reg_write           (reg_write),
    .mem_to_reg          (mem_to_reg),
    .illegal_instruction (illegal_instruction),
    .state               (state)
  );

  always #5 clk = ~clk;

  //                                   state  ill   rd    wr    lord  irw   pcw   pcs   a     b     op    rw    m2r
  localparam logic [19:0] E_ZERO     = {4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0};
  localparam logic [19:0] E_FETCH    = {4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0};
  localparam logic [19:0] E_FETCH_R  = {4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0};
  localparam logic [19:0] E_DECODE   = {4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0};
  localparam logic [19:0] E_MEMADR   = {4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd0, 1'b0, 2'd0};
  localparam logic [19:0] E_MEMREAD  = {4'd3,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0};
  localparam logic [19:0] E_MEMWB    = {4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1};
  localparam logic [19:0] E_MEMWRITE = {4'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0};
  localparam logic [19:0] E_EXR      = {4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd2, 1'b0, 2'd0};
  localparam logic [19:0] E_EXI      = {4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd2, 1'b0, 2'd0};
  localparam logic [19:0] E_ALUWB    = {4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0};
  localparam logic [19:0] E_BR_T     = {4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0, 2'd1, 1'b0, 2'd0};
  localparam logic [19:0] E_BR_N     = {4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd1, 1'b0, 2'd0};
  localparam logic [19:0] E_JAL      = {4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b1, 2'd2};
  localparam logic [19:0] E_JALR     = {4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 2'd0, 1'b1, 2'd2};
  localparam logic [19:0] E_LUI      = {4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 2'd0, 1'b0, 2'd0};
  localparam logic [19:0] E_AUIPC    = {4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd2, 2'd0, 1'b0, 2'd0};
  localparam logic [19:0] E_TRAP     = {4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0};

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS = 7'b1110011, OP_BAD = 7'h7F;

  logic [19:0] observed;

  // Drive inputs, compare every output word in the middle of the cycle, then advance one clock.
  task automatic step(input string tag, input logic rst, input logic [6:0] op,
                      input logic mr, input logic bt, input logic [19:0] expected);
    reset           = rst;
    opcode          = op;
    memory_response = mr;
    branch_taken    = bt;
    #3;
    observed = {state, illegal_instruction, memory_read, memory_write, lord, ir_write, pc_write,
                pc_source, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg};
    vectors++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %05h expected %05h", tag, observed, expected);
      end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; memory_response = 1'b0; branch_taken = 1'b0;
    @(posedge clk); #1;

    // Reset: outputs forced low even with a response pending.
    step("reset0", 1'b1, OP_I, 1'b1, 1'b0, E_ZERO);
    step("reset1", 1'b1, OP_I, 1'b1, 1'b0, E_ZERO);

    // ADDI 0x00500093, zero-wait memory.
    step("addi_fetch",  1'b0, OP_I, 1'b1, 1'b0, E_FETCH_R);
    step("addi_decode", 1'b0, OP_I, 1'b1, 1'b0, E_DECODE);
    step("addi_exi",    1'b0, OP_I, 1'b1, 1'b0, E_EXI);
    step("addi_wb",     1'b0, OP_I, 1'b1, 1'b0, E_ALUWB);

    // LW with one fetch wait and two data-read wait states.
    step("lw_fetch_wait", 1'b0, OP_LOAD, 1'b0, 1'b0, E_FETCH);
    step("lw_fetch",      1'b0, OP_LOAD, 1'b1, 1'b0, E_FETCH_R);
    step("lw_decode",     1'b0, OP_LOAD, 1'b1, 1'b0, E_DECODE);
    step("lw_memadr",     1'b0, OP_LOAD, 1'b1, 1'b0, E_MEMADR);
    step("lw_read_w1",    1'b0, OP_LOAD, 1'b0, 1'b0, E_MEMREAD);
    step("lw_read_w2",    1'b0, OP_LOAD, 1'b0, 1'b0, E_MEMREAD);
    step("lw_read_done",  1'b0, OP_LOAD, 1'b1, 1'b0, E_MEMREAD);
    step("lw_memwb",      1'b0, OP_LOAD, 1'b1, 1'b0, E_MEMWB);

    // SW zero wait.
    step("sw_fetch",  1'b0, OP_STORE, 1'b1, 1'b0, E_FETCH_R);
    step("sw_decode", 1'b0, OP_STORE, 1'b1, 1'b0, E_DECODE);
    step("sw_memadr", 1'b0, OP_STORE, 1'b1, 1'b0, E_MEMADR);
    step("sw_write",  1'b0, OP_STORE, 1'b1, 1'b0, E_MEMWRITE);

    // R-type.
    step("add_fetch",  1'b0, OP_R, 1'b1, 1'b0, E_FETCH_R);
    step("add_decode", 1'b0, OP_R, 1'b1, 1'b0, E_DECODE);
    step("add_exr",    1'b0, OP_R, 1'b1, 1'b0, E_EXR);
    step("add_wb",     1'b0, OP_R, 1'b1, 1'b0, E_ALUWB);

    // BEQ taken then not taken.
    step("beq1_fetch",  1'b0, OP_BR, 1'b1, 1'b1, E_FETCH_R);
    step("beq1_decode", 1'b0, OP_BR, 1'b1, 1'b1, E_DECODE);
    step("beq1_taken",  1'b0, OP_BR, 1'b1, 1'b1, E_BR_T);
    step("beq2_fetch",  1'b0, OP_BR, 1'b1, 1'b0, E_FETCH_R);
    step("beq2_decode", 1'b0, OP_BR, 1'b1, 1'b0, E_DECODE);
    step("beq2_nottkn", 1'b0, OP_BR, 1'b1, 1'b0, E_BR_N);

    // JAL then JALR.
    step("jal_fetch",   1'b0, OP_JAL, 1'b1, 1'b0, E_FETCH_R);
    step("jal_decode",  1'b0, OP_JAL, 1'b1, 1'b0, E_DECODE);
    step("jal_exec",    1'b0, OP_JAL, 1'b1, 1'b0, E_JAL);
    step("jalr_fetch",  1'b0, OP_JALR, 1'b1, 1'b0, E_FETCH_R);
    step("jalr_decode", 1'b0, OP_JALR, 1'b1, 1'b0, E_DECODE);
    step("jalr_exec",   1'b0, OP_JALR, 1'b1, 1'b0, E_JALR);

    // LUI and AUIPC.
    step("lui_fetch",    1'b0, OP_LUI, 1'b1, 1'b0, E_FETCH_R);
    step("lui_decode",   1'b0, OP_LUI, 1'b1, 1'b0, E_DECODE);
    step("lui_exec",     1'b0, OP_LUI, 1'b1, 1'b0, E_LUI);
    step("lui_wb",       1'b0, OP_LUI, 1'b1, 1'b0, E_ALUWB);
    step("auipc_fetch",  1'b0, OP_AUIPC, 1'b1, 1'b0, E_FETCH_R);
    step("auipc_decode", 1'b0, OP_AUIPC, 1'b1, 1'b0, E_DECODE);
    step("auipc_exec",   1'b0, OP_AUIPC, 1'b1, 1'b0, E_AUIPC);
    step("auipc_wb",     1'b0, OP_AUIPC, 1'b1, 1'b0, E_ALUWB);

    // SYSTEM treated as NOP: back to FETCH after DECODE.
    step("nop_fetch",  1'b0, OP_SYS, 1'b1, 1'b0, E_FETCH_R);
    step("nop_decode", 1'b0, OP_SYS, 1'b1, 1'b0, E_DECODE);

    // Illegal opcode: trap is sticky and ignores memory_response.
    step("ill_fetch",  1'b0, OP_BAD, 1'b1, 1'b0, E_FETCH_R);
    step("ill_decode", 1'b0, OP_BAD, 1'b1, 1'b0, E_DECODE);
    for (int i = 0; i < 11; i++) begin
      step("ill_trap", 1'b0, (i % 2 == 0) ? OP_BAD : OP_I, i[0], i[1], E_TRAP);
    end
    step("ill_reset",     1'b1, OP_BAD, 1'b1, 1'b0, E_ZERO);
    step("ill_restarted", 1'b0, OP_STORE, 1'b0, 1'b0, E_FETCH);

    // Reset during a MEMWRITE wait: request drops in the reset cycle, FETCH follows.
    step("swr_fetch",  1'b0, OP_STORE, 1'b1, 1'b0, E_FETCH_R);
    step("swr_decode", 1'b0, OP_STORE, 1'b1, 1'b0, E_DECODE);
    step("swr_memadr", 1'b0, OP_STORE, 1'b0, 1'b0, E_MEMADR);
    step("swr_wait1",  1'b0, OP_STORE, 1'b0, 1'b0, E_MEMWRITE);
    step("swr_wait2",  1'b0, OP_STORE, 1'b0, 1'b0, E_MEMWRITE);
    step("swr_wait3",  1'b0, OP_STORE, 1'b0, 1'b0, E_MEMWRITE);
    step("swr_reset",  1'b1, OP_STORE, 1'b1, 1'b0, E_ZERO);
    step("swr_fetch2", 1'b0, OP_STORE, 1'b0, 1'b0, E_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
